// File: rtl/id_ex_shift_stage.sv
// ---------------------------------------------------------------------------
// id_ex_shift_stage
//
// ID/EX pipeline register for shift-class R-type instructions. It captures
// the decoded instruction, forwards rt (and rs for variable shifts) from the
// EX/MEM and MEM/WB stages, and presents operand, amount, operation and
// write-back control to the EX-stage barrel shifter.
//
// Build option:
//   SHIFT_VAR_EN  - when defined, sllv/srlv/srav are accepted and the shift
//                   amount comes from forwarded rs[4:0]. When undefined those
//                   codes load as bubbles and the rs path is not built.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_valid                 ID slot holds a real instruction
//   id_funct                 R-type funct field
//   id_shamt                 instruction shamt field
//   id_rs_addr/rt_addr/rd_addr  register specifiers
//   id_rs_data/rt_data       register-file read data
//   stall                    hold this stage (forwarded data still refreshes)
//   flush                    turn the EX slot into a bubble (beats stall)
//   exmem_*                  EX/MEM forwarding source (highest priority)
//   memwb_*                  MEM/WB forwarding source
//   ex_valid                 EX holds a valid shift instruction
//   ex_shift_data            forwarded rt value, 0 when not valid
//   ex_shift_amt             shift amount, 0 when not valid
//   ex_shift_op              00 sll, 01 srl, 11 sra, 10 none
//   ex_rd_addr               destination register
//   ex_wr_en                 result must be written back (never to $zero)
// ---------------------------------------------------------------------------
module id_ex_shift_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_shamt,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_wr_en,
    input  logic [REG_AW-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_wr_en,
    input  logic [REG_AW-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_shift_data,
    output logic [4:0]        ex_shift_amt,
    output logic [1:0]        ex_shift_op,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_wr_en
);

    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [1:0] OP_NONE = 2'b10;

    // ------------------------------------------------------------------
    // Decode of the instruction currently in ID
    // ------------------------------------------------------------------
    logic       id_is_shift;
    logic [1:0] id_op;
    logic       id_is_var;

    always_comb begin
        id_is_shift = 1'b0;
        id_op       = OP_NONE;
        id_is_var   = 1'b0;
        case (id_funct)
            6'b000000: begin id_is_shift = 1'b1; id_op = OP_SLL; end
            6'b000010: begin id_is_shift = 1'b1; id_op = OP_SRL; end
            6'b000011: begin id_is_shift = 1'b1; id_op = OP_SRA; end
`ifdef SHIFT_VAR_EN
            6'b000100: begin id_is_shift = 1'b1; id_op = OP_SLL; id_is_var = 1'b1; end
            6'b000110: begin id_is_shift = 1'b1; id_op = OP_SRL; id_is_var = 1'b1; end
            6'b000111: begin id_is_shift = 1'b1; id_op = OP_SRA; id_is_var = 1'b1; end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic               valid_q,   valid_d;
    logic [1:0]         op_q,      op_d;
    logic [SHAMT_W-1:0] shamt_q,   shamt_d;
    logic [REG_AW-1:0]  rt_addr_q, rt_addr_d;
    logic [REG_AW-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]  rt_data_q, rt_data_d;
    logic [DATA_W-1:0]  fwd_rt;

`ifdef SHIFT_VAR_EN
    logic               var_q,     var_d;
    logic [REG_AW-1:0]  rs_addr_q, rs_addr_d;
    logic [DATA_W-1:0]  rs_data_q, rs_data_d;
    logic [DATA_W-1:0]  fwd_rs;
`else
    // rs is not needed when only immediate shifts exist.
    logic unused_rs;
    assign unused_rs = ^{id_rs_addr, id_rs_data, id_is_var};
`endif

    // ------------------------------------------------------------------
    // Forwarding on the registered source fields. $zero never forwards;
    // EX/MEM is younger than MEM/WB so it wins.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_rt = rt_data_q;
        if (rt_addr_q != '0) begin
            if (exmem_wr_en && (exmem_rd_addr == rt_addr_q)) begin
                fwd_rt = exmem_result;
            end else if (memwb_wr_en && (memwb_rd_addr == rt_addr_q)) begin
                fwd_rt = memwb_result;
            end
        end
    end

`ifdef SHIFT_VAR_EN
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_addr_q != '0) begin
            if (exmem_wr_en && (exmem_rd_addr == rs_addr_q)) begin
                fwd_rs = exmem_result;
            end else if (memwb_wr_en && (memwb_rd_addr == rs_addr_q)) begin
                fwd_rs = memwb_result;
            end
        end
    end

    // Only the low five bits of rs set a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^fwd_rs[DATA_W-1:SHAMT_W];
`endif

    // ------------------------------------------------------------------
    // Next state: flush > stall > load (reset handled in the flop block)
    // ------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        shamt_d   = shamt_q;
        rt_addr_d = rt_addr_q;
        rd_addr_d = rd_addr_q;
        rt_data_d = rt_data_q;
`ifdef SHIFT_VAR_EN
        var_d     = var_q;
        rs_addr_d = rs_addr_q;
        rs_data_d = rs_data_q;
`endif
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            // Capture forwarded values so a producer that retires during
            // the stall is still seen after it leaves the pipeline.
            rt_data_d = fwd_rt;
`ifdef SHIFT_VAR_EN
            rs_data_d = fwd_rs;
`endif
        end else begin
            valid_d   = id_valid && id_is_shift;
            op_d      = id_op;
            shamt_d   = id_shamt;
            rt_addr_d = id_rt_addr;
            rd_addr_d = id_rd_addr;
            rt_data_d = id_rt_data;
`ifdef SHIFT_VAR_EN
            var_d     = id_is_var;
            rs_addr_d = id_rs_addr;
            rs_data_d = id_rs_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            shamt_q   <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            rt_data_q <= '0;
`ifdef SHIFT_VAR_EN
            var_q     <= 1'b0;
            rs_addr_q <= '0;
            rs_data_q <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            shamt_q   <= shamt_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
            rt_data_q <= rt_data_d;
`ifdef SHIFT_VAR_EN
            var_q     <= var_d;
            rs_addr_q <= rs_addr_d;
            rs_data_q <= rs_data_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs: data and amount are zeroed for bubbles so nothing stale
    // reaches the shifter.
    // ------------------------------------------------------------------
    assign ex_valid      = valid_q;
    assign ex_shift_data = valid_q ? fwd_rt : '0;
    assign ex_shift_op   = valid_q ? op_q : OP_NONE;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_wr_en      = valid_q && (rd_addr_q != '0);

`ifdef SHIFT_VAR_EN
    assign ex_shift_amt  = !valid_q ? '0 :
                           (var_q ? fwd_rs[SHAMT_W-1:0] : shamt_q);
`else
    assign ex_shift_amt  = valid_q ? shamt_q : '0;
`endif

endmodule
